rom_dump_arbiter: RTL and testbench
===================================

Name: rom_dump_arbiter

Overview:
- Shares the single-ported, combinational instruction ROM (10-bit word address, 32-bit data) between two requesters.
  - The CPU instruction-fetch path.
  - A debug burst reader that streams a ROM address range to a display or serial sink over a valid/ready handshake.
- Sits between the CPU's IF stage and the ROM. The CPU keeps priority, and a starvation guard guarantees forward progress for the debug burst.

Parameters:
- ADDR_W, 10, ROM word-address width.
- DATA_W, 32, ROM word width.
- MAX_STALL, 4, maximum consecutive cycles the debug reader may be denied before it is forced a grant (range 1..15).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- CpuReq  in  1  CPU wants an instruction this cycle.
- CpuAddr  in  ADDR_W  CPU fetch word address.
- CpuData  out  DATA_W  fetched instruction, combinational from RomData.
- CpuStall  out  1  CPU fetch not served this cycle; CPU must hold PC.
- DbgStart  in  1  start burst (sampled only in IDLE).
- DbgBase  in  ADDR_W  burst start address, sampled with DbgStart.
- DbgLen  in  ADDR_W  burst length in words; 0 means 2^ADDR_W (1024).
- DbgBusy  out  1  burst in progress (state != IDLE).
- DbgValid  out  1  DbgData/DbgAddr hold a word.
- DbgReady  in  1  sink accepts the word.
- DbgAddr  out  ADDR_W  address of the presented word.
- DbgData  out  DATA_W  presented word.
- DbgDone  out  1  one-cycle pulse after the last word is accepted.
- RomAddr  out  ADDR_W  to ROM Address.
- RomData  in  DATA_W  from ROM Data.

Behaviour:
- Reset:
  - State = IDLE; all registered outputs are 0 (DbgValid, DbgAddr, DbgData, DbgDone, DbgBusy).
  - Counters are cleared.
  - A reset mid-burst aborts it with no DbgDone pulse.
- Grant, combinational from the current registered state:
  - dbg_grant = (state==READ) && (!CpuReq || starve==MAX_STALL).
  - RomAddr = dbg_grant ? cur_addr : CpuAddr.
  - CpuData = RomData, always.
  - CpuStall = CpuReq && dbg_grant.
  - CPU latency is 0 cycles when not stalled.
- Starvation counter `starve`:
  - Increments when state==READ && CpuReq && !dbg_grant.
  - Clears on dbg_grant, in any state other than READ, and on Reset.
  - Saturates at MAX_STALL.
- FSM states: IDLE, READ, HOLD, DONE.
  - IDLE: on DbgStart, cur_addr <= DbgBase, remaining <= DbgLen (0 loads 1024, so remaining is ADDR_W+1 bits), go to READ. With no DbgStart, stay.
  - READ: on dbg_grant, DbgData <= RomData, DbgAddr <= cur_addr, DbgValid <= 1, go to HOLD. Otherwise stay.
  - HOLD: while DbgValid && !DbgReady, DbgData, DbgAddr and DbgValid are stable. On DbgReady:
    - DbgValid <= 0 and remaining <= remaining-1.
    - If remaining==1, go to DONE.
    - Otherwise cur_addr <= cur_addr+1 (modulo 2^ADDR_W, so 1023 wraps to 0) and go to READ.
  - DONE: DbgDone=1 for exactly this cycle, then go to IDLE.
- DbgStart is ignored outside IDLE, including in DONE.
- DbgReady is ignored while DbgValid=0.
- Peak debug throughput is 1 word per 2 cycles.
- Worst-case debug latency per word is MAX_STALL+1 cycles in READ under continuous CpuReq.
- The CPU is stalled at most 1 cycle out of every MAX_STALL+1 while a burst is active.
- The CPU never stalls in IDLE, HOLD or DONE.

Decomposition:
- Shared package rom_arb_pkg holds:
  - The state encoding (IDLE=2'd0, READ=2'd1, HOLD=2'd2, DONE=2'd3).
  - ADDR_W/DATA_W defaults.
  - The length-decode function (0 maps to 2^ADDR_W).
- One sub-module, rom_dump_fsm: the burst FSM, address/remaining counters and output register.
- The top level keeps the grant mux and the starvation counter.

Test Plan:
- In all scenarios the bench ROM model returns RomData = 32'hC0DE0000 | RomAddr.
- CPU only, no burst: CpuReq=1, CpuAddr=5 -> same-cycle CpuData=32'hC0DE0005, CpuStall=0, DbgBusy=0.
- Idle CPU burst: DbgStart with DbgBase=10, DbgLen=3, DbgReady=1, CpuReq=0 -> DbgAddr 10,11,12 with DbgData C0DE000A/B/C on alternate cycles, then one DbgDone pulse, DbgBusy=0 on the next cycle.
- Starvation, MAX_STALL=4, CpuReq held 1, burst DbgBase=0, DbgLen=2:
  - CpuStall is 0 for 4 READ cycles, then 1 for exactly one cycle in which RomAddr=0.
  - The pattern repeats for address 1.
  - Total stalls = 2.
- Backpressure: DbgReady=0 for 6 cycles in HOLD -> DbgValid, DbgAddr and DbgData stay constant, and there is no further ROM access for the burst; the next address is read only after DbgReady=1.
- Wrap and zero length:
  - DbgBase=1022, DbgLen=3 -> addresses 1022, 1023, 0.
  - DbgLen=0 -> exactly 1024 words accepted before DbgDone.
- Reset and restart:
  - Assert Reset during HOLD of a 5-word burst -> next cycle DbgValid=0, DbgBusy=0, no DbgDone.
  - DbgStart pulsed in READ is ignored (the burst base is unchanged).

Source files
------------

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared state encoding, width defaults and burst-length decode for the ROM dump arbiter
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    // A zero length means the full address space (2^aw words).
    function automatic logic [31:0] decode_len(input logic [31:0] len, input int aw);
        return (len == 32'd0) ? (32'd1 << aw) : len;
    endfunction

endpackage

// File: rtl/rom_dump_fsm.sv
// rom_dump_fsm: debug burst reader FSM with address/remaining counters and registered word output
// Ports: clk, rst (sync, active-high); start/base/len load a burst in IDLE; grant = ROM slot won this cycle;
// rom_data = ROM word at cur_addr; ready = sink accepts; reading = FSM in READ; cur_addr = next address to read;
// valid/addr/data = presented word; done = one-cycle end-of-burst pulse; busy = burst in progress.
module rom_dump_fsm
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    input  logic              grant,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              ready,
    output logic              reading,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              done,
    output logic              busy
);

    localparam int REM_W = ADDR_W + 1;

    state_t           state;
    logic [REM_W-1:0] remaining;

    assign reading = (state == READ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            valid     <= 1'b0;
            addr      <= '0;
            data      <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cur_addr  <= base;
                    remaining <= REM_W'(decode_len(32'(len), ADDR_W));
                    busy      <= 1'b1;
                    state     <= READ;
                end
                READ: if (grant) begin
                    data  <= rom_data;
                    addr  <= cur_addr;
                    valid <= 1'b1;
                    state <= HOLD;
                end
                // valid is always set in HOLD, so ready alone completes the handshake
                HOLD: if (ready) begin
                    valid     <= 1'b0;
                    remaining <= remaining - 1'b1;
                    if (remaining == REM_W'(1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cur_addr <= cur_addr + 1'b1;
                        state    <= READ;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/rom_dump_arbiter.sv
// rom_dump_arbiter: shares a combinational instruction ROM between CPU fetch (priority) and a debug burst reader
// Ports: clk, rst (sync, active-high); cpu_req/cpu_addr in, cpu_data/cpu_stall out for the fetch path;
// dbg_start/dbg_base/dbg_len start a burst, dbg_busy flags it; dbg_valid/dbg_ready/dbg_addr/dbg_data stream words;
// dbg_done pulses after the last word; rom_addr/rom_data connect to the ROM.
module rom_dump_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_STALL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_stall,
    input  logic              dbg_start,
    input  logic [ADDR_W-1:0] dbg_base,
    input  logic [ADDR_W-1:0] dbg_len,
    output logic              dbg_busy,
    output logic              dbg_valid,
    input  logic              dbg_ready,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              dbg_done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam logic [3:0] STALL_MAX = 4'(MAX_STALL);

    logic              reading;
    logic              dbg_grant;
    logic [3:0]        starve;
    logic [ADDR_W-1:0] cur_addr;

    // CPU wins unless the debug reader has already been denied STALL_MAX times in a row
    assign dbg_grant = reading && (!cpu_req || starve == STALL_MAX);
    assign rom_addr  = dbg_grant ? cur_addr : cpu_addr;
    assign cpu_data  = rom_data;
    assign cpu_stall = cpu_req && dbg_grant;

    always_ff @(posedge clk) begin
        if (rst || !reading || dbg_grant)
            starve <= '0;
        else if (cpu_req && starve != STALL_MAX)
            starve <= starve + 1'b1;
    end

    rom_dump_fsm #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .start    (dbg_start),
        .base     (dbg_base),
        .len      (dbg_len),
        .grant    (dbg_grant),
        .rom_data (rom_data),
        .ready    (dbg_ready),
        .reading  (reading),
        .cur_addr (cur_addr),
        .valid    (dbg_valid),
        .addr     (dbg_addr),
        .data     (dbg_data),
        .done     (dbg_done),
        .busy     (dbg_busy)
    );

endmodule

// File: tb/tb_rom_dump_arbiter.sv
// tb_rom_dump_arbiter: directed self-checking bench for rom_dump_arbiter with a C0DE0000|addr ROM model
module tb_rom_dump_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [31:0] cpu_data;
    logic        cpu_stall;
    logic        dbg_start = 1'b0;
    logic [9:0]  dbg_base = '0;
    logic [9:0]  dbg_len = '0;
    logic        dbg_busy;
    logic        dbg_valid;
    logic        dbg_ready = 1'b0;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        dbg_done;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;

    int checks = 0;
    int errors = 0;
    logic [9:0]  wa[$];
    logic [31:0] wd[$];

    rom_dump_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_STALL(4)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_stall(cpu_stall), .dbg_start(dbg_start), .dbg_base(dbg_base), .dbg_len(dbg_len),
        .dbg_busy(dbg_busy), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .dbg_done(dbg_done), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [9:0] a);
        return 32'hC0DE0000 | {22'b0, a};
    endfunction

    assign rom_data = rom(rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [9:0] base, input logic [9:0] len);
        dbg_base  = base;
        dbg_len   = len;
        dbg_start = 1'b1;
        tick();
        dbg_start = 1'b0;
    endtask

    task automatic collect(input int budget, output int nw, output int nd);
        nw = 0;
        nd = 0;
        wa.delete();
        wd.delete();
        for (int i = 0; i < budget && nd == 0; i++) begin
            if (dbg_valid && dbg_ready) begin
                wa.push_back(dbg_addr);
                wd.push_back(dbg_data);
                nw++;
            end
            if (dbg_done) nd++;
            tick();
        end
    endtask

    initial begin
        int nw, nd, stalls;
        logic [9:0] a;
        tick();
        tick();
        chk("rst_valid", 32'(dbg_valid), 32'd0);
        chk("rst_busy", 32'(dbg_busy), 32'd0);
        chk("rst_done", 32'(dbg_done), 32'd0);
        chk("rst_addr", 32'(dbg_addr), 32'd0);
        chk("rst_data", dbg_data, 32'd0);
        rst = 1'b0;
        tick();

        // CPU only
        cpu_req  = 1'b1;
        cpu_addr = 10'd5;
        #1;
        chk("cpu_data", cpu_data, 32'hC0DE0005);
        chk("cpu_stall_idle", 32'(cpu_stall), 32'd0);
        chk("cpu_rom_addr", 32'(rom_addr), 32'd5);
        chk("cpu_busy", 32'(dbg_busy), 32'd0);

        // burst with idle CPU: words on cycles 1,3,5 after start, done on 6, idle on 7
        cpu_req   = 1'b0;
        dbg_ready = 1'b1;
        start(10'd10, 10'd3);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("b3_valid%0d", k), 32'(dbg_valid), 32'((k % 2 == 1) && k <= 5));
            if (k % 2 == 1 && k <= 5) begin
                chk($sformatf("b3_addr%0d", k), 32'(dbg_addr), 32'(9 + (k + 1) / 2));
                chk($sformatf("b3_data%0d", k), dbg_data, 32'hC0DE0009 + 32'((k + 1) / 2));
            end
            chk($sformatf("b3_done%0d", k), 32'(dbg_done), 32'(k == 6));
            chk($sformatf("b3_busy%0d", k), 32'(dbg_busy), 32'(k < 7));
        end

        // starvation: CPU always requesting, two words from 0
        cpu_req  = 1'b1;
        cpu_addr = 10'd100;
        start(10'd0, 10'd2);
        stalls = 0;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("sv_stall%0d", c), 32'(cpu_stall), 32'(c == 4 || c == 10));
            if (cpu_stall) begin
                stalls++;
                chk($sformatf("sv_romaddr%0d", c), 32'(rom_addr), 32'(c == 10));
            end else begin
                chk($sformatf("sv_cpudata%0d", c), cpu_data, 32'hC0DE0064);
            end
            tick();
        end
        chk("sv_stalls", 32'(stalls), 32'd2);
        chk("sv_done", 32'(dbg_done), 32'd1);
        chk("sv_done_nostall", 32'(cpu_stall), 32'd0);
        tick();

        // backpressure in HOLD
        cpu_req   = 1'b0;
        cpu_addr  = 10'd7;
        dbg_ready = 1'b0;
        start(10'd20, 10'd2);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("bp_valid%0d", i), 32'(dbg_valid), 32'd1);
            chk($sformatf("bp_addr%0d", i), 32'(dbg_addr), 32'd20);
            chk($sformatf("bp_data%0d", i), dbg_data, 32'hC0DE0014);
            chk($sformatf("bp_rom%0d", i), 32'(rom_addr), 32'd7);
            tick();
        end
        dbg_ready = 1'b1;
        tick();
        chk("bp_read_valid", 32'(dbg_valid), 32'd0);
        chk("bp_read_rom", 32'(rom_addr), 32'd21);
        tick();
        chk("bp_addr2", 32'(dbg_addr), 32'd21);
        chk("bp_data2", dbg_data, 32'hC0DE0015);
        tick();
        chk("bp_done", 32'(dbg_done), 32'd1);
        tick();

        // address wrap
        start(10'd1022, 10'd3);
        collect(50, nw, nd);
        chk("wr_words", 32'(nw), 32'd3);
        chk("wr_done", 32'(nd), 32'd1);
        if (nw == 3) begin
            chk("wr_a0", 32'(wa[0]), 32'd1022);
            chk("wr_a1", 32'(wa[1]), 32'd1023);
            chk("wr_a2", 32'(wa[2]), 32'd0);
            chk("wr_d2", wd[2], 32'hC0DE0000);
        end
        chk("wr_idle_busy", 32'(dbg_busy), 32'd0);
        chk("wr_idle_done", 32'(dbg_done), 32'd0);

        // zero length means 1024 words
        start(10'd5, 10'd0);
        collect(3000, nw, nd);
        chk("z_words", 32'(nw), 32'd1024);
        chk("z_done", 32'(nd), 32'd1);
        for (int i = 0; i < nw && i < 1024; i++) begin
            a = 10'(5 + i);
            if (wa[i] !== a || wd[i] !== rom(a)) begin
                chk($sformatf("z_addr%0d", i), 32'(wa[i]), 32'(a));
                chk($sformatf("z_data%0d", i), wd[i], rom(a));
            end
        end
        chk("z_last", 32'(nw > 0 ? wa[nw - 1] : 10'd0), 32'd4);

        // start ignored in READ, then reset during HOLD
        cpu_req   = 1'b1;
        dbg_ready = 1'b0;
        start(10'd50, 10'd5);
        dbg_base  = 10'd200;
        dbg_start = 1'b1;
        tick();
        dbg_start = 1'b0;
        cpu_req   = 1'b0;
        #1;
        chk("rs_rom", 32'(rom_addr), 32'd50);
        tick();
        chk("rs_addr", 32'(dbg_addr), 32'd50);
        chk("rs_data", dbg_data, 32'hC0DE0032);
        chk("rs_valid_hold", 32'(dbg_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("rs_valid", 32'(dbg_valid), 32'd0);
        chk("rs_busy", 32'(dbg_busy), 32'd0);
        chk("rs_done", 32'(dbg_done), 32'd0);
        rst = 1'b0;
        tick();
        chk("rs_done2", 32'(dbg_done), 32'd0);
        chk("rs_busy2", 32'(dbg_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
